// File: rtl/resp_line_parser_pkg.sv
// resp_parser_pkg: shared definitions for the response line parser.
//   - parser state enum (TERM_LF exists only when RESP_CRLF_EN is defined)
//   - error cause codes carried on err_code
//   - ASCII constants for the "RESP:" header and line terminators
//   - ascii_hex_to_nibble: {valid, nibble} decode of one ASCII hex character
//   - hdr_char: expected header byte at a given header index
package resp_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HEX,
`ifdef RESP_CRLF_EN
    ST_TERM,
    ST_TERM_LF
`else
    ST_TERM
`endif
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_HEX = 2'd1;
  localparam logic [1:0] ERR_BAD_LEN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_S     = 8'h53;
  localparam logic [7:0] ASC_P     = 8'h50;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;

  // Bit 4 is the valid flag; bits 3:0 the nibble (0 when invalid).
  function automatic logic [4:0] ascii_hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10.
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] hdr_char(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = ASC_R;
      3'd1:    c = ASC_E;
      3'd2:    c = ASC_S;
      3'd3:    c = ASC_P;
      default: c = ASC_COLON;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/resp_line_parser_if.sv
// resp_line_parser_if: byte-in / word-out bundle of the response line parser.
//   flush, rx_data, rx_valid          : byte stream and abort, driven by master
//   resp_value, resp_valid            : parsed word and its update strobe
//   resp_error, err_code              : abort strobe and its cause
//   busy                              : parser is inside a line
// Modports: master = byte source / result consumer, slave = parser.
interface resp_line_parser_if #(
  parameter int HEX_DIGITS = 32
);
  logic                    flush;
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [4*HEX_DIGITS-1:0] resp_value;
  logic                    resp_valid;
  logic                    resp_error;
  logic [1:0]              err_code;
  logic                    busy;

  modport master (
    output flush, rx_data, rx_valid,
    input  resp_value, resp_valid, resp_error, err_code, busy
  );

  modport slave (
    input  flush, rx_data, rx_valid,
    output resp_value, resp_valid, resp_error, err_code, busy
  );
endinterface

// File: rtl/resp_line_parser.sv
// resp_line_parser: recognises "RESP:" + HEX_DIGITS hex chars + LF in a UART
// byte stream and emits the packed word (first digit in the MSBs) with a
// one-cycle resp_valid, or a one-cycle resp_error with a cause on err_code.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : resp_line_parser_if.slave (flush, rx_data/rx_valid in;
//            resp_value, resp_valid, resp_error, err_code, busy out)
// Build option: RESP_CRLF_EN accepts an optional CR right before the LF.
//
// state   | meaning
// IDLE    | waiting for 'R'
// HDR     | matching "RESP:" at hdr_idx
// HEX     | shifting in hex digits, dig_cnt counts them
// TERM    | all digits seen, waiting for LF (or CR with RESP_CRLF_EN)
// TERM_LF | CR seen, waiting for LF (RESP_CRLF_EN only)
module resp_line_parser
  import resp_parser_pkg::*;
#(
  parameter int HEX_DIGITS     = 32,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input logic               clk,
  input logic               rst_n,
  resp_line_parser_if.slave bus
);

  localparam int W   = 4 * HEX_DIGITS;
  localparam int DCW = $clog2(HEX_DIGITS + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  localparam logic [DCW-1:0] DIG_LAST = DCW'(HEX_DIGITS - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [2:0]       hdr_idx;
  logic [DCW-1:0]   dig_cnt;
  logic [TCW-1:0]   tmo_cnt;
  logic [W-1:0]     shreg;
  logic [W-1:0]     resp_value_q;
  logic             resp_valid_q;
  logic             resp_error_q;
  logic [1:0]       err_code_q;

  logic [4:0]       hex_dec;
  logic             hdr_match;
  logic             is_lf;
  logic             is_cr;

  assign hex_dec   = ascii_hex_to_nibble(bus.rx_data);
  assign hdr_match = (bus.rx_data == hdr_char(hdr_idx));
  assign is_lf     = (bus.rx_data == ASC_LF);
  assign is_cr     = (bus.rx_data == ASC_CR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hdr_idx      <= 3'd0;
      dig_cnt      <= '0;
      tmo_cnt      <= '0;
      shreg        <= '0;
      resp_value_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      err_code_q   <= ERR_NONE;

      if (state != ST_IDLE && bus.flush) begin
        // Flush beats a byte arriving in the same cycle; nothing is reported.
        state   <= ST_IDLE;
        hdr_idx <= 3'd0;
        dig_cnt <= '0;
        tmo_cnt <= '0;
      end else if (bus.rx_valid) begin
        // A byte always restarts the gap timer, even on the expiry cycle.
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == ASC_R) begin
              state   <= ST_HDR;
              hdr_idx <= 3'd1;
            end
          end

          ST_HDR: begin
            if (hdr_match) begin
              if (hdr_idx == 3'd4) begin
                state   <= ST_HEX;
                hdr_idx <= 3'd0;
                dig_cnt <= '0;
              end else begin
                hdr_idx <= hdr_idx + 3'd1;
              end
            end else if (bus.rx_data == ASC_R) begin
              hdr_idx <= 3'd1;
            end else begin
              state   <= ST_IDLE;
              hdr_idx <= 3'd0;
            end
          end

          ST_HEX: begin
            if (hex_dec[4]) begin
              shreg   <= {shreg[W-5:0], hex_dec[3:0]};
              dig_cnt <= dig_cnt + DCW'(1);
              if (dig_cnt == DIG_LAST) begin
                state <= ST_TERM;
              end
`ifdef RESP_CRLF_EN
            end else if (is_lf || is_cr) begin
`else
            end else if (is_lf) begin
`endif
              resp_error_q <= 1'b1;
              err_code_q   <= ERR_BAD_LEN;
              state        <= ST_IDLE;
              dig_cnt      <= '0;
            end else begin
              resp_error_q <= 1'b1;
              err_code_q   <= ERR_BAD_HEX;
              state        <= ST_IDLE;
              dig_cnt      <= '0;
            end
          end

          ST_TERM: begin
            if (is_lf) begin
              resp_value_q <= shreg;
              resp_valid_q <= 1'b1;
              state        <= ST_IDLE;
              dig_cnt      <= '0;
`ifdef RESP_CRLF_EN
            end else if (is_cr) begin
              state <= ST_TERM_LF;
`endif
            end else begin
              resp_error_q <= 1'b1;
              err_code_q   <= ERR_BAD_LEN;
              state        <= ST_IDLE;
              dig_cnt      <= '0;
            end
          end

`ifdef RESP_CRLF_EN
          ST_TERM_LF: begin
            if (is_lf) begin
              resp_value_q <= shreg;
              resp_valid_q <= 1'b1;
            end else begin
              resp_error_q <= 1'b1;
              err_code_q   <= ERR_BAD_LEN;
            end
            state   <= ST_IDLE;
            dig_cnt <= '0;
          end
`endif

          default: begin
            state   <= ST_IDLE;
            hdr_idx <= 3'd0;
            dig_cnt <= '0;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          resp_error_q <= 1'b1;
          err_code_q   <= ERR_TIMEOUT;
          state        <= ST_IDLE;
          hdr_idx      <= 3'd0;
          dig_cnt      <= '0;
          tmo_cnt      <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TCW'(1);
        end
      end
    end
  end

  assign bus.resp_value = resp_value_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_resp_line_parser.sv
// Bench for resp_line_parser: directed lines plus randomized byte streams,
// every cycle compared with a line-level reference model.
module tb_resp_line_parser;

  localparam int HD  = 32;
  localparam int TMO = 100;
`ifdef RESP_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  resp_line_parser_if #(.HEX_DIGITS(HD)) bus ();

  resp_line_parser #(
    .HEX_DIGITS(HD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: bytes of the line collected so far
  logic [7:0]   line[$];
  int           gap;
  logic [127:0] m_value;
  logic         m_valid;
  logic         m_error;
  logic [1:0]   m_code;
  logic [7:0]   hdr [5] = '{8'h52, 8'h45, 8'h53, 8'h50, 8'h3A};

  int           n_valid = 0;
  int           n_err = 0;
  logic [1:0]   last_code = 2'd0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  task automatic model_reset();
    line.delete();
    gap = 0;
    m_value = '0;
    m_valid = 1'b0;
    m_error = 1'b0;
    m_code = 2'd0;
  endtask

  task automatic model_err(input logic [1:0] c);
    m_error = 1'b1;
    m_code = c;
    line.delete();
    gap = 0;
  endtask

  task automatic model_accept();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < HD; i++) v = (v << 4) | 128'(hex_val(line[5+i]));
    m_value = v;
    m_valid = 1'b1;
    line.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    bit has_cr;
    n = line.size();
    if (n == 0) begin
      if (b == 8'h52) line.push_back(b);
    end else if (n < 5) begin
      if (b == hdr[n]) line.push_back(b);
      else begin
        line.delete();
        if (b == 8'h52) line.push_back(b);
      end
    end else begin
      has_cr = (line[n-1] == CR);
      if (has_cr) begin
        if (b == LF) model_accept();
        else model_err(2'd2);
      end else if (n - 5 < HD) begin
        if (hex_val(b) >= 0) line.push_back(b);
        else if (b == LF || (CRLF && b == CR)) model_err(2'd2);
        else model_err(2'd1);
      end else begin
        if (b == LF) model_accept();
        else if (CRLF && b == CR) line.push_back(b);
        else model_err(2'd2);
      end
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic fl);
    m_valid = 1'b0;
    m_error = 1'b0;
    m_code = 2'd0;
    if (line.size() != 0 && fl) begin
      line.delete();
      gap = 0;
    end else if (v) begin
      gap = 0;
      model_byte(b);
    end else if (line.size() != 0) begin
      gap++;
      if (gap >= TMO) model_err(2'd3);
    end
  endtask

  task automatic compare();
    chk("busy", bus.busy, line.size() != 0);
    chk("resp_valid", bus.resp_valid, m_valid);
    chk("resp_error", bus.resp_error, m_error);
    chk("err_code", bus.err_code, m_code);
    chk("resp_value", bus.resp_value, m_value);
    if (bus.resp_valid) n_valid++;
    if (bus.resp_error) begin
      n_err++;
      last_code = bus.err_code;
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic fl);
    bus.rx_valid = v;
    bus.rx_data = b;
    bus.flush = fl;
    @(posedge clk);
    #1;
    model_step(v, b, fl);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input string s, input int maxgap, input int fpct);
    logic fl;
    for (int i = 0; i < s.len(); i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      fl = ($urandom_range(0, 99) < fpct);
      cyc(1'b1, s[i], fl);
    end
  endtask

  function automatic string rand_hex(input int n);
    string d;
    string s;
    int k;
    d = "0123456789abcdefABCDEF";
    s = "";
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 21);
      s = {s, d.substr(k, k)};
    end
    return s;
  endfunction

  function automatic string gen_line();
    string s;
    string junk;
    int k;
    int p;
    junk = "RG\n:x\rYN 0";
    k = $urandom_range(0, 10);
    case (k)
      0, 1, 2, 3: s = {"RESP:", rand_hex(HD), "\n"};
      4:          s = {"RESP:", rand_hex($urandom_range(HD - 2, HD + 2)), "\n"};
      5: begin
        s = {"RESP:", rand_hex(HD), "\n"};
        p = $urandom_range(0, s.len() - 1);
        if ($urandom_range(0, 1) == 0) s.putc(p, junk[$urandom_range(0, junk.len() - 1)]);
        else s.putc(p, 8'($urandom_range(1, 255)));
      end
      6:          s = {"YNxR", rand_hex(3), "RE\nY"};
      7:          s = {"RERES", "RESP:", rand_hex(HD), "\n"};
      8:          s = {"RESP:", rand_hex(HD), "\r\n"};
      9:          s = {"RESP:", rand_hex(HD), "\r\r\n"};
      default:    s = {"xRESP:", rand_hex(HD), "\n"};
    endcase
    return s;
  endfunction

  logic [127:0] prev_value;
  int           e0;
  int           v0;
  string        s;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.flush = 1'b0;
    model_reset();

    // reset state
    #2;
    chk("rst_value", bus.resp_value, 128'h0);
    chk("rst_valid", bus.resp_valid, 1'b0);
    chk("rst_error", bus.resp_error, 1'b0);
    chk("rst_code", bus.err_code, 2'd0);
    chk("rst_busy", bus.busy, 1'b0);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 8'h00, 1'b0);
    compare();

    // well-formed line, back-to-back bytes
    e0 = n_err;
    send("RESP:00112233445566778899AABBCCDDEEFF\n", 0, 0);
    idle(2);
    chk("t1_value", bus.resp_value, 128'h00112233445566778899AABBCCDDEEFF);
    chk("t1_nerr", n_err - e0, 0);

    // resync on a second 'R'
    s = "xYRRESP:";
    for (int i = 0; i < HD; i++) s = {s, "a"};
    send({s, "\n"}, 1, 0);
    idle(2);
    chk("t2_value", bus.resp_value, {32{4'hA}});
    chk("t2_nerr", n_err - e0, 0);

    // one digit short
    prev_value = bus.resp_value;
    send("RESP:0123456789ABCDEF0123456789ABCDE\n", 0, 0);
    idle(1);
    chk("t3_code", last_code, 2'd2);
    chk("t3_value", bus.resp_value, prev_value);

    // bad hex digit, then a good line
    e0 = n_err;
    send("RESP:12G", 0, 0);
    chk("t4_code", last_code, 2'd1);
    chk("t4_nerr", n_err - e0, 1);
    send("RESP:DEADBEEF0123456789abcdefCAFEF00D\n", 2, 0);
    idle(1);
    chk("t4_value", bus.resp_value, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);

    // gap timeout
    e0 = n_err;
    send("RESP:12", 0, 0);
    idle(TMO + 3);
    chk("tmo_nerr", n_err - e0, 1);
    chk("tmo_code", last_code, 2'd3);

    // a byte on the expiry cycle keeps the line alive
    e0 = n_err;
    v0 = n_valid;
    send("RESP:1", 0, 0);
    idle(TMO - 1);
    send({"23456789ABCDEF0123456789ABCDEF0", "\n"}, 0, 0);
    idle(1);
    chk("tmo_edge_nerr", n_err - e0, 0);
    chk("tmo_edge_nvalid", n_valid - v0, 1);
    chk("tmo_edge_value", bus.resp_value, 128'h123456789ABCDEF0123456789ABCDEF0);

    // flush with a byte drops it silently; flush in IDLE does nothing
    e0 = n_err;
    send("RESP:12", 0, 0);
    cyc(1'b1, "3", 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    idle(2);
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_nerr", n_err - e0, 0);

    // asynchronous reset in the middle of a line
    send("RESP:AB", 0, 0);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst_value", bus.resp_value, 128'h0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_error", bus.resp_error, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b0, 8'h00, 1'b0);
    compare();
    send("RESP:FFEEDDCCBBAA99887766554433221100\n", 0, 0);
    idle(1);
    chk("arst_next_value", bus.resp_value, 128'hFFEEDDCCBBAA99887766554433221100);

    // CR before LF
    v0 = n_valid;
    e0 = n_err;
    prev_value = bus.resp_value;
    send("RESP:0123456789ABCDEF0123456789ABCDEF\r\n", 0, 0);
    idle(1);
    chk("crlf_nvalid", n_valid - v0, CRLF ? 1 : 0);
    chk("crlf_nerr", n_err - e0, CRLF ? 0 : 1);
    chk("crlf_value", bus.resp_value,
        CRLF ? 128'h0123456789ABCDEF0123456789ABCDEF : prev_value);

    // randomized streams
    for (int ep = 0; ep < 200; ep++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = gen_line();
        p_split(s);
      end else begin
        send(gen_line(), $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? 3 : 0);
      end
      if ($urandom_range(0, 9) == 0) idle($urandom_range(TMO - 3, TMO + 5));
      else idle($urandom_range(0, 4));
    end

    idle(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // send a line with a pause near the timeout somewhere inside it
  task automatic p_split(input string ln);
    int cut;
    cut = $urandom_range(1, ln.len() - 1);
    send(ln.substr(0, cut - 1), 0, 0);
    idle($urandom_range(TMO - 2, TMO + 1));
    send(ln.substr(cut, ln.len() - 1), 0, 0);
  endtask

endmodule

// File: doc/resp_line_parser.md
# resp_line_parser

Byte-stream parser between `uart_rx` and the challenge-response verifier. It consumes received UART bytes and recognises response lines of the form `RESP:` + HEX_DIGITS hex characters + LF. A well-formed line produces a packed 128-bit response word with a one-cycle valid strobe. A malformed or stalled line produces a one-cycle error strobe with a cause code. The verifier then only compares words and no longer buffers or decodes ASCII.

## Interface
Parameters:
- `HEX_DIGITS`, 32, number of hex characters per line; the response word is 4*HEX_DIGITS bits wide.
- `TIMEOUT_CYCLES`, 12_000_000, maximum allowed gap between bytes inside a line (1 s at 12 MHz).

Ports:
- `clk`  in  1  system clock (12 MHz).
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  abort the line in progress and return to IDLE.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  single-cycle strobe qualifying `rx_data`.
- `resp_value`  out  4*HEX_DIGITS  last successfully parsed word, MSB first (first digit in bits [4*HEX_DIGITS-1 -: 4]).
- `resp_valid`  out  1  one-cycle pulse: `resp_value` was updated.
- `resp_error`  out  1  one-cycle pulse: a line was aborted.
- `err_code`  out  2  cause, valid while `resp_error` is high.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values: `resp_value`=0, `resp_valid`=0, `resp_error`=0, `err_code`=0, `busy`=0, state IDLE, shift register 0, counters 0.
- State IDLE:
  - `rx_data`=='R' → HDR with header index 1.
  - Any other byte is ignored silently. This covers Y/N commands and noise.
- State HDR: compare the byte against "RESP:" at the header index.
  - Match: increment the index; after ':' go to HEX with digit count 0.
  - Mismatch: if the byte is 'R', go to HDR with index 1 (resync); otherwise go to IDLE. No error is flagged.
- State HEX:
  - Digits '0'-'9', 'A'-'F' and 'a'-'f' shift in: `shreg <= {shreg[4*HEX_DIGITS-5:0], nib}`; digit count +1.
  - When the count reaches HEX_DIGITS, go to TERM.
  - LF before HEX_DIGITS digits → error BAD_LEN.
  - Any other byte → error BAD_HEX.
- State TERM:
  - LF: `resp_value <= shreg`, pulse `resp_valid`, go to IDLE.
  - Any other byte (including an extra hex digit) → error BAD_LEN.
- Error action: pulse `resp_error`, set `err_code`, go to IDLE. `resp_value` is unchanged.
- Error codes: 0 NONE, 1 BAD_HEX, 2 BAD_LEN, 3 TIMEOUT.
- Timeout counter:
  - Cleared on every accepted `rx_valid` and held at 0 in IDLE.
  - Counts while in HDR, HEX or TERM.
  - Reaching TIMEOUT_CYCLES-1 → error TIMEOUT.
- Digit counter width: $clog2(HEX_DIGITS+1). Timeout counter width: $clog2(TIMEOUT_CYCLES).

## Timing
- `resp_valid` and `resp_error` are registered. They rise in the cycle after the terminating or offending byte's `rx_valid`, and last exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted; there is no backpressure.
- `flush` with `rx_valid` in the same cycle: flush wins, the byte is dropped, and no strobe is issued.
- `flush` in IDLE has no effect.
- Timeout expiry in the same cycle as `rx_valid`: the byte wins and the counter clears.
- A `resp_valid` or `resp_error` pulse never coincides with another pulse.
- Reset asserted mid-line returns all outputs to their reset values asynchronously. A pending pulse is lost.
- End-to-end latency: 1 cycle from the LF strobe to `resp_valid`.

## Configuration
- `RESP_CRLF_EN` defined:
  - In TERM, a CR (0x0D) is accepted once and moves to TERM_LF.
  - TERM_LF requires LF; anything else → BAD_LEN.
  - In HEX, CR is treated like an early LF → BAD_LEN.
- `RESP_CRLF_EN` undefined: CR is an ordinary invalid byte (BAD_HEX in HEX, BAD_LEN in TERM), and the TERM_LF state does not exist.

## Structure
- Shared package `resp_parser_pkg`:
  - state enum.
  - `err_code` localparams.
  - ASCII constants ('R','E','S','P',':',LF,CR).
  - function `ascii_hex_to_nibble` returning {valid, nibble[3:0]}. This replaces the per-module helper currently duplicated in top.
- No sub-module: the timeout counter and decoder are small enough to stay inline.

## Test plan
- "RESP:00112233445566778899AABBCCDDEEFF\n" → one `resp_valid`, `resp_value`=128'h00112233445566778899AABBCCDDEEFF, `resp_error` never high.
- "xYRRESP:" + 32×'a' + "\n" → resync on the second 'R'; `resp_value`=128'hAAAA…AAAA (all 32 nibbles A); no error.
- "RESP:" + 31 digits + "\n" → `resp_error`, `err_code`=2; `resp_value` keeps its previous value.
- "RESP:12G…" → `resp_error`, `err_code`=1 the cycle after 'G'; the following valid line parses correctly.
- "RESP:12" then idle for TIMEOUT_CYCLES (use a small TIMEOUT_CYCLES, e.g. 100) → `err_code`=3 exactly at expiry; `busy` falls the same cycle.
- Reset pulse after "RESP:AB" → outputs 0 at once; the next full line parses with no residue. With `RESP_CRLF_EN`, "…FF\r\n" → `resp_valid`.
